// File: rtl/mp_add_seq_if.sv
// Word-stream bundle for mp_add_seq: operand input, adder link, result output.
// The master side feeds operand words, plays the adder and drains results.
interface mp_add_seq_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_first;
    logic             in_last;
    logic             in_sub;

    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_s;
    logic             adder_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_last;
    logic             out_carry;
    logic             out_ovf;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_sub,
        input  in_ready,
        input  adder_a, adder_b, adder_cin,
        output adder_s, adder_cout,
        input  out_valid, out_sum, out_last, out_carry, out_ovf, out_idx,
        output out_ready
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_sub,
        output in_ready,
        output adder_a, adder_b, adder_cin,
        input  adder_s, adder_cout,
        output out_valid, out_sum, out_last, out_carry, out_ovf, out_idx,
        input  out_ready
    );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer around an external carry-propagate adder.
// Words arrive LSW first; the carry is chained across cycles via carry_q.
module mp_add_seq #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    mp_add_seq_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             carry_q;
    logic             sub_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_last_q;
    logic             out_carry_q;
    logic             out_ovf_q;

    logic             is_first;
    logic             sub_eff;
    logic             in_ready;
    logic             xfer;
    logic             ovf_d;
    logic [WIDTH-1:0] b_eff;

    // A word seen while idle starts a new operation even without in_first.
    assign is_first = bus.in_first | (state_q == IDLE);
    assign sub_eff  = is_first ? bus.in_sub : sub_q;
    assign b_eff    = bus.in_b ^ {WIDTH{sub_eff}};

    assign bus.adder_a   = bus.in_a;
    assign bus.adder_b   = b_eff;
    assign bus.adder_cin = is_first ? bus.in_sub : carry_q;

    assign in_ready     = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = in_ready;
    assign xfer         = bus.in_valid & in_ready;

    assign ovf_d = bus.in_last
                 & (bus.in_a[WIDTH-1] == b_eff[WIDTH-1])
                 & (bus.adder_s[WIDTH-1] != bus.in_a[WIDTH-1]);

    always_comb begin
        idx_d = '0;
        if (!is_first) begin
            idx_d = (&idx_q) ? idx_q : idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = bus.in_last ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (xfer) begin
            carry_q     <= bus.adder_cout;
            if (is_first) begin
                sub_q <= bus.in_sub;
            end
            idx_q       <= idx_d;
            out_valid_q <= 1'b1;
            out_sum_q   <= bus.adder_s;
            out_last_q  <= bus.in_last;
            out_carry_q <= bus.adder_cout;
            out_ovf_q   <= ovf_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_idx   = idx_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed and random wide operations, checked
// word by word against whole-operand integer arithmetic.
module tb_mp_add_seq;
    localparam int W  = 16;
    localparam int IW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    mp_add_seq_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    mp_add_seq #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The external adder: a plain W-bit add with carry in/out.
    logic [W:0] add_full;
    assign add_full = {1'b0, bus.adder_a} + {1'b0, bus.adder_b}
                    + {{W{1'b0}}, bus.adder_cin};
    assign bus.adder_s    = add_full[W-1:0];
    assign bus.adder_cout = add_full[W];

    task automatic check(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [63:0] lowmask(input int k);
        return (64'd1 << k) - 64'd1;
    endfunction

    // Carry (or no-borrow) out of the low k bits of the whole operation.
    function automatic logic exp_carry(input logic [63:0] a, input logic [63:0] b,
                                       input logic sub, input int k);
        logic [63:0] m;
        m = lowmask(k);
        if (sub) return (a & m) >= (b & m);
        return (((a & m) + (b & m)) >> k) != 64'd0;
    endfunction

    function automatic logic exp_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input logic sub, input int n);
        int     bits;
        longint sa, sb, r, mx, mn;
        bits = 16 * n;
        sa = $signed(a << (64 - bits)) >>> (64 - bits);
        sb = $signed(b << (64 - bits)) >>> (64 - bits);
        r  = sub ? sa - sb : sa + sb;
        mx = (longint'(1) <<< (bits - 1)) - 1;
        mn = -mx - 1;
        return (r > mx) || (r < mn);
    endfunction

    task automatic run_op(input string tag, input int n,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic noise,
                          input logic first0, input int nsend);
        logic [63:0] r;
        logic [15:0] aw, bw;
        logic        cin;
        r = (sub ? a - b : a + b) & lowmask(16 * n);
        for (int i = 0; i < nsend; i++) begin
            aw  = a[i*16 +: 16];
            bw  = b[i*16 +: 16];
            cin = (i == 0) ? sub : exp_carry(a, b, sub, 16 * i);
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_a      = aw;
            bus.in_b      = bw;
            bus.in_first  = (i == 0) ? first0 : 1'b0;
            bus.in_last   = (i == n - 1);
            bus.in_sub    = (i != 0 && noise) ? ~sub : sub;
            #1;
            check(tag, "in_ready", bus.in_ready, 1);
            check(tag, "adder_a", bus.adder_a, aw);
            check(tag, "adder_b", bus.adder_b, bw ^ {16{sub}});
            check(tag, "adder_cin", bus.adder_cin, cin);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check(tag, "out_valid", bus.out_valid, 1);
            check(tag, "out_sum", bus.out_sum, r[i*16 +: 16]);
            check(tag, "out_carry", bus.out_carry, exp_carry(a, b, sub, 16 * (i + 1)));
            check(tag, "out_last", bus.out_last, (i == n - 1));
            check(tag, "out_ovf", bus.out_ovf,
                  (i == n - 1) ? exp_ovf(a, b, sub, n) : 1'b0);
            check(tag, "out_idx", bus.out_idx, i);
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check(tag, "out_valid", bus.out_valid, 0);
    endtask

    initial begin
        int          n;
        logic [63:0] a, b;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;

        #1;
        check("reset", "out_valid", bus.out_valid, 0);
        check("reset", "out_sum", bus.out_sum, 0);
        check("reset", "out_idx", bus.out_idx, 0);
        check("reset", "out_carry", bus.out_carry, 0);
        check("reset", "in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add32", 2, 64'h0001_FFFF, 64'h0000_0001, 1'b0, 1'b0, 1'b1, 2);
        run_op("sub1w", 1, 64'h0000, 64'h0001, 1'b1, 1'b0, 1'b1, 1);
        run_op("ovf1w", 1, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b1, 1);
        run_op("sub48", 3, 64'h0001_0000_0000, 64'h1, 1'b1, 1'b1, 1'b1, 3);
        run_op("abandon", 3, 64'h1234_5678_9ABC, 64'h0FED_CBA9_8765,
               1'b0, 1'b0, 1'b1, 2);
        run_op("restart", 2, 64'h8000_0000, 64'h8000_0000, 1'b1, 1'b0, 1'b1, 2);
        drain("drain0");

        // Backpressure: output held, input blocked, then a bubble-free handoff.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h1234;
        bus.in_b      = 16'h1111;
        bus.in_first  = 1'b1;
        bus.in_last   = 1'b1;
        bus.in_sub    = 1'b0;
        @(posedge clk);
        #1;
        check("bp", "out_sum0", bus.out_sum, 16'h2345);
        @(negedge clk);
        bus.in_a = 16'h00FF;
        bus.in_b = 16'h0001;
        #1;
        check("bp", "in_ready_lo", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("bp", "out_sum_held", bus.out_sum, 16'h2345);
        check("bp", "out_valid_held", bus.out_valid, 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("bp", "in_ready_hi", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp", "out_sum1", bus.out_sum, 16'h0100);
        check("bp", "out_valid1", bus.out_valid, 1);
        drain("bp_drain");

        // Reset mid-operation, then a word without in_first starts fresh.
        run_op("rst_pre", 2, 64'h0000_0003, 64'h0000_0001, 1'b0, 1'b0, 1'b1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid", "out_valid", bus.out_valid, 0);
        check("rst_mid", "out_idx", bus.out_idx, 0);
        check("rst_mid", "in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("rst_post", 1, 64'h5, 64'h3, 1'b1, 1'b0, 1'b0, 1);
        run_op("nofirst", 2, 64'h0000_FFFF, 64'h0000_0001, 1'b0, 1'b0, 1'b0, 2);

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 3);
            a = {$urandom, $urandom} & lowmask(16 * n);
            b = {$urandom, $urandom} & lowmask(16 * n);
            run_op("rand", n, a, b, 1'(($urandom_range(0, 1))),
                   1'($urandom_range(0, 1)), 1'b1,
                   ($urandom_range(0, 7) == 0) ? 1 : n);
        end
        drain("end");

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer that sits directly upstream of the 16-bit carry-propagate adder and also consumes its result.
- Accepts wide operands one 16-bit word per transfer, least-significant word first.
- Drives the adder's a/b/c_in inputs combinationally from the accepted word.
- Chains the adder's c_out into the next word's c_in through a carry register, so operands of any length are added or subtracted across cycles.
- Results leave through a registered output stage with a valid/ready handshake.

Parameters:
WIDTH, 16, word width; must match the adder width
IDX_W, 8, width of the word-index counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_a  in  WIDTH  operand A word
in_b  in  WIDTH  operand B word
in_first  in  1  word is the least-significant word of a new operation
in_last  in  1  word is the most-significant word of the operation
in_sub  in  1  1 = A-B, 0 = A+B; sampled only on first words
adder_a  out  WIDTH  to adder a; equals in_a
adder_b  out  WIDTH  to adder b; equals in_b XOR {WIDTH{sub_eff}}
adder_cin  out  1  to adder c_in
adder_s  in  WIDTH  adder sum (combinational, same cycle)
adder_cout  in  1  adder carry out
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts result word
out_sum  out  WIDTH  result word
out_last  out  1  result word is the final word of the operation
out_carry  out  1  carry out of this word; on the last word, 1 = no borrow for subtraction
out_ovf  out  1  signed overflow; valid only when out_last=1, otherwise 0
out_idx  out  IDX_W  word index within the operation; 0 = first word

Behaviour:
- Reset: asynchronous, active-low, on rst_n=0.
  - All outputs and registers clear to 0: out_valid, out_sum, out_last, out_carry, out_ovf, out_idx, carry_q, sub_q, idx_q.
  - State returns to IDLE.
  - in_ready is 1 out of reset.
- States:
  - IDLE: awaiting the first word.
  - RUN: inside a multi-word operation.
- First-word detection: is_first = in_first | (state==IDLE). A word arriving in IDLE with in_first=0 is treated as a first word.
- Effective controls:
  - sub_eff = is_first ? in_sub : sub_q.
  - adder_cin = is_first ? in_sub : carry_q.
  - Adder-facing outputs are purely combinational from the current inputs and registers. They are valid whenever in_valid=1, whether or not the word is accepted.
- Handshake:
  - in_ready = ~out_valid | out_ready, so a full output register plus a stalled consumer blocks input.
  - A transfer occurs on a rising clk edge where in_valid & in_ready.
- On each accepted word, at the clock edge:
  - out_sum <= adder_s; out_carry <= adder_cout; out_last <= in_last; out_valid <= 1.
  - carry_q <= adder_cout.
  - On first words: sub_q <= in_sub.
  - out_idx <= is_first ? 0 : idx_q+1. idx_q tracks the same value and saturates at 2^IDX_W-1.
  - out_ovf <= in_last & (in_a[MSB]==adder_b[MSB]) & (adder_s[MSB]!=in_a[MSB]).
  - Next state: IDLE if in_last, else RUN.
- in_first=1 while in RUN abandons the current operation and restarts from this word. No error flag is raised.
- in_first=1 together with in_last=1 is a single-word operation; state stays IDLE.
- Output stage:
  - A cycle with out_valid & out_ready and no new transfer clears out_valid.
  - When both occur in the same cycle, the new word is loaded and out_valid stays 1.
  - out_* hold stable while out_valid & ~out_ready.
- Latency: 1 cycle from input acceptance to out_valid. Full throughput is one word per cycle when out_ready=1.
- Reset mid-operation discards the partial operation and any pending output word.

Test Plan:
- 32-bit add 0x0001_FFFF+0x0000_0001.
  - Word 0 (first): a=FFFF, b=0001 -> out_sum=0000, out_carry=1, out_idx=0.
  - Word 1 (last): a=0001, b=0000 -> out_sum=0002, out_carry=0, out_last=1, out_ovf=0, out_idx=1.
- Single-word subtract 0000-0001 with first=last=1, sub=1:
  - adder_b=FFFE, adder_cin=1 -> out_sum=FFFF, out_carry=0 (borrow), out_ovf=0.
- Signed overflow 7FFF+0001 single word -> out_sum=8000, out_ovf=1.
- 48-bit subtract with in_sub toggled to 0 on words 1 and 2:
  - in_sub must be ignored after the first word.
  - 0x0001_0000_0000 - 0x0000_0000_0001 -> words FFFF, FFFF, 0000; last out_carry=1.
- Backpressure: hold out_ready=0 after one word.
  - in_ready=0, out_sum held.
  - Raise out_ready together with a new in_valid -> back-to-back transfer with no bubble.
- Reset and restart:
  - rst_n=0 after word 0 of a 2-word op -> out_valid=0 immediately, state IDLE.
  - Next word sent without in_first -> treated as first: adder_cin=in_sub, out_idx=0.
